// File: rtl/matmul_apb_slave.sv
`default_nettype none
// ============================================================================
// Module   : matmul_apb_slave
// Brief    : APB register slave for the matmul core: control, operands,
//            flags and scratchpad read-through.
// Revision : 1.0
// ============================================================================
module matmul_apb_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              psel_i,
    input  logic                              penable_i,
    input  logic                              pwrite_i,
    input  logic [MAX_DIM-1:0]                pstrb_i,
    input  logic [BUS_WIDTH-1:0]              pwdata_i,
    input  logic [ADDR_WIDTH-1:0]             paddr_i,
    output logic                              pready_o,
    output logic                              pslverr_o,
    output logic [BUS_WIDTH-1:0]              prdata_o,
    output logic                              start_o,
    output logic [BUS_WIDTH-1:0]              control_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0]      opa_o,
    output logic [BUS_WIDTH*MAX_DIM-1:0]      opb_o,
    input  logic                              core_busy_i,
    input  logic [BUS_WIDTH-1:0]              flags_i,
    input  logic                              flags_we_i,
    output logic                              busy_o,
    output logic                              sp_rd_en_o,
    output logic [1:0]                        sp_rd_sel_o,
    output logic [2*$clog2(MAX_DIM)-1:0]      sp_rd_idx_o,
    input  logic [BUS_WIDTH-1:0]              sp_rd_data_i
);

    localparam int c_idx_w  = $clog2(MAX_DIM);
    localparam int c_line_w = 2 * c_idx_w;

    localparam logic [4:0] c_reg_control = 5'h00;
    localparam logic [4:0] c_reg_opa     = 5'h04;
    localparam logic [4:0] c_reg_opb     = 5'h08;
    localparam logic [4:0] c_reg_flags   = 5'h0C;

    localparam logic [31:0] c_op_lines = 32'(MAX_DIM);
    localparam logic [31:0] c_sp_lines = 32'(MAX_DIM * MAX_DIM);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_sp_wait = 2'd1;
    localparam logic [1:0] c_st_resp    = 2'd2;

    logic [1:0]              r_state;
    logic [4:0]              r_region;
    logic [c_idx_w-1:0]      r_idx;
    logic                    r_write;
    logic                    r_err;
    logic [BUS_WIDTH-1:0]    r_wdata;
    logic [MAX_DIM-1:0]      r_strb;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [BUS_WIDTH-1:0]    r_prdata;
    logic                    r_start;
    logic                    r_start_pending;
    logic [BUS_WIDTH-1:0]    r_control;
    logic [BUS_WIDTH-1:0]    r_flags;
    logic [BUS_WIDTH-1:0]    r_opa [MAX_DIM];
    logic [BUS_WIDTH-1:0]    r_opb [MAX_DIM];

    logic [4:0]              w_region;
    logic [c_line_w-1:0]     w_line;
    logic [c_idx_w-1:0]      w_idx;
    logic [31:0]             w_line_ext;
    logic                    w_busy;
    logic                    w_setup;
    logic                    w_misalign;
    logic                    w_is_sp;
    logic                    w_is_op;
    logic                    w_op_line_bad;
    logic                    w_sp_line_bad;
    logic                    w_err;
    logic                    w_sp_read;
    logic                    w_done;
    logic                    w_commit;
    logic [BUS_WIDTH-1:0]    w_rdata;
    logic [BUS_WIDTH-1:0]    w_old;
    logic [BUS_WIDTH-1:0]    w_merged;
    logic                    w_unused;

    function automatic logic [BUS_WIDTH-1:0] f_merge(
        input logic [BUS_WIDTH-1:0] old_v,
        input logic [BUS_WIDTH-1:0] new_v,
        input logic [MAX_DIM-1:0]   strb
    );
        logic [BUS_WIDTH-1:0] res;
        res = old_v;
        for (int b = 0; b < MAX_DIM; b++) begin
            if (strb[b]) begin
                res[b*DATA_WIDTH +: DATA_WIDTH] = new_v[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        return res;
    endfunction

    assign w_region   = paddr_i[4:0];
    assign w_line     = paddr_i[5 +: c_line_w];
    assign w_idx      = w_line[c_idx_w-1:0];
    assign w_line_ext = 32'(w_line);
    assign w_unused   = ^paddr_i[ADDR_WIDTH-1:5+c_line_w];

    assign w_busy  = core_busy_i | r_start_pending;
    assign w_setup = (r_state == c_st_idle) & psel_i & ~penable_i;

    assign w_misalign    = |paddr_i[1:0];
    assign w_is_sp       = w_region[4];
    assign w_is_op       = (w_region == c_reg_opa) || (w_region == c_reg_opb);
    assign w_op_line_bad = w_is_op && (w_line_ext >= c_op_lines);
    assign w_sp_line_bad = w_is_sp && (w_line_ext >= c_sp_lines);
    assign w_err = w_misalign
                 | (pwrite_i & ((w_region == c_reg_flags) | w_is_sp))
                 | w_op_line_bad
                 | w_sp_line_bad
                 | (pwrite_i & w_busy)
                 | (w_is_sp & ~pwrite_i & w_busy);
    assign w_sp_read = w_is_sp & ~pwrite_i & ~w_err;

    // Scratchpad request is issued in the setup cycle so its data lands in SP_WAIT.
    assign sp_rd_en_o  = w_setup & w_sp_read & ~rst_i;
    assign sp_rd_sel_o = sp_rd_en_o ? w_region[3:2] : 2'b00;
    assign sp_rd_idx_o = sp_rd_en_o ? w_line : '0;

    // A dropped psel in the response phase still finishes the transfer.
    assign w_done   = (r_state == c_st_resp) & (penable_i | ~psel_i);
    assign w_commit = w_done & r_write & ~r_err;

    always_comb begin
        w_rdata = '0;
        case (w_region)
            c_reg_control: w_rdata = r_control;
            c_reg_opa:     w_rdata = r_opa[w_idx];
            c_reg_opb:     w_rdata = r_opb[w_idx];
            c_reg_flags:   w_rdata = r_flags;
            default:       w_rdata = '0;
        endcase
    end

    always_comb begin
        w_old = '0;
        case (r_region)
            c_reg_control: w_old = r_control;
            c_reg_opa:     w_old = r_opa[r_idx];
            c_reg_opb:     w_old = r_opb[r_idx];
            default:       w_old = '0;
        endcase
    end

    assign w_merged = f_merge(w_old, r_wdata, r_strb);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state         <= c_st_idle;
            r_region        <= '0;
            r_idx           <= '0;
            r_write         <= 1'b0;
            r_err           <= 1'b0;
            r_wdata         <= '0;
            r_strb          <= '0;
            r_pready        <= 1'b0;
            r_pslverr       <= 1'b0;
            r_prdata        <= '0;
            r_start         <= 1'b0;
            r_start_pending <= 1'b0;
            r_control       <= '0;
            r_flags         <= '0;
            for (int i = 0; i < MAX_DIM; i++) begin
                r_opa[i] <= '0;
                r_opb[i] <= '0;
            end
        end else begin
            r_start <= 1'b0;
            if (r_start) begin
                r_start_pending <= 1'b0;
            end

            // A core flag update takes priority over the clear that accompanies start.
            if (flags_we_i) begin
                r_flags <= flags_i;
            end else if (r_start) begin
                r_flags <= '0;
            end

            case (r_state)
                c_st_idle: begin
                    if (w_setup) begin
                        r_region <= w_region;
                        r_idx    <= w_idx;
                        r_write  <= pwrite_i;
                        r_wdata  <= pwdata_i;
                        r_strb   <= pstrb_i;
                        r_err    <= w_err;
                        if (w_sp_read) begin
                            r_state <= c_st_sp_wait;
                        end else begin
                            r_state   <= c_st_resp;
                            r_pready  <= 1'b1;
                            r_pslverr <= w_err;
                            r_prdata  <= (w_err | pwrite_i) ? '0 : w_rdata;
                        end
                    end
                end
                c_st_sp_wait: begin
                    r_state   <= c_st_resp;
                    r_pready  <= 1'b1;
                    r_pslverr <= 1'b0;
                    r_prdata  <= sp_rd_data_i;
                end
                c_st_resp: begin
                    if (w_done) begin
                        r_state   <= c_st_idle;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                        r_prdata  <= '0;
                        if (w_commit) begin
                            case (r_region)
                                c_reg_control: begin
                                    r_control <= {w_merged[BUS_WIDTH-1:1], 1'b0};
                                    if (w_merged[0]) begin
                                        r_start         <= 1'b1;
                                        r_start_pending <= 1'b1;
                                    end
                                end
                                c_reg_opa: r_opa[r_idx] <= w_merged;
                                c_reg_opb: r_opb[r_idx] <= w_merged;
                                default: ;
                            endcase
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_pack
            assign opa_o[gi*BUS_WIDTH +: BUS_WIDTH] = r_opa[gi];
            assign opb_o[gi*BUS_WIDTH +: BUS_WIDTH] = r_opb[gi];
        end
    endgenerate

    assign pready_o  = r_pready;
    assign pslverr_o = r_pslverr;
    assign prdata_o  = r_prdata;
    assign start_o   = r_start;
    assign control_o = r_control;
    assign busy_o    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_matmul_apb_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_apb_slave
// Brief    : Self-checking bench for matmul_apb_slave (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_matmul_apb_slave;

    localparam int DW = 8;
    localparam int BW = 32;
    localparam int AW = 32;
    localparam int MD = 4;
    localparam int LW = 4;

    logic              clk;
    logic              rst;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [MD-1:0]     pstrb;
    logic [BW-1:0]     pwdata;
    logic [AW-1:0]     paddr;
    logic              pready;
    logic              pslverr;
    logic [BW-1:0]     prdata;
    logic              start;
    logic [BW-1:0]     control;
    logic [BW*MD-1:0]  opa;
    logic [BW*MD-1:0]  opb;
    logic              core_busy;
    logic [BW-1:0]     flags_in;
    logic              flags_we;
    logic              busy;
    logic              sp_en;
    logic [1:0]        sp_sel;
    logic [LW-1:0]     sp_idx;
    logic [BW-1:0]     sp_data;

    matmul_apb_slave #(
        .DATA_WIDTH(DW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(MD)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite), .pstrb_i(pstrb),
        .pwdata_i(pwdata), .paddr_i(paddr),
        .pready_o(pready), .pslverr_o(pslverr), .prdata_o(prdata),
        .start_o(start), .control_o(control), .opa_o(opa), .opb_o(opb),
        .core_busy_i(core_busy), .flags_i(flags_in), .flags_we_i(flags_we), .busy_o(busy),
        .sp_rd_en_o(sp_en), .sp_rd_sel_o(sp_sel), .sp_rd_idx_o(sp_idx), .sp_rd_data_i(sp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Scratchpad model: answers one cycle after a request, zero otherwise.
    function automatic logic [BW-1:0] sp_model(input logic [1:0] sel, input logic [LW-1:0] idx);
        if (sel == 2'd2 && idx == 4'd5) return 32'hDEADBEEF;
        return {24'hA5A5A5, 2'b00, sel, idx};
    endfunction

    int            sp_pulses;
    logic [1:0]    last_sel;
    logic [LW-1:0] last_idx;

    always @(posedge clk) begin
        if (rst) begin
            sp_pulses <= 0;
            last_sel  <= '0;
            last_idx  <= '0;
            sp_data   <= '0;
        end else if (sp_en) begin
            sp_pulses <= sp_pulses + 1;
            last_sel  <= sp_sel;
            last_idx  <= sp_idx;
            sp_data   <= sp_model(sp_sel, sp_idx);
        end else begin
            sp_data <= '0;
        end
    end

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];

    task automatic apb(input string nm, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] erd, input logic eerr, input int elat);
        exp_t e;
        int   lat;
        e.name = nm; e.rd = erd; e.err = eerr; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
        @(negedge clk);
        penable = 1'b1;
        lat = 1;
        while (!pready && lat < 8) begin
            chk($sformatf("%s_outputs_before_ready", nm), 256'({prdata, pslverr}), 256'(0));
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!pready) begin
            chk($sformatf("%s_pready_timeout", e.name), 256'(pready), 256'(1));
        end else begin
            chk($sformatf("%s_prdata", e.name), 256'(prdata), 256'(e.rd));
            chk($sformatf("%s_pslverr", e.name), 256'(pslverr), 256'(e.err));
            chk($sformatf("%s_latency", e.name), 256'(lat), 256'(e.lat));
        end
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] erd;
        logic        eerr;
        int          elat;
        logic [31:0] eopa2;
    } vec_t;

    vec_t vt[14];
    int   p0;

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = '0;
        pwdata = '0; paddr = '0; core_busy = 1'b0; flags_in = '0; flags_we = 1'b0;

        vt[0]  = '{1'b1, 32'h44,  32'h04030201, 4'hF, 32'h0,        1'b0, 1, 32'h04030201};
        vt[1]  = '{1'b1, 32'h44,  32'h000000FF, 4'h1, 32'h0,        1'b0, 1, 32'h040302FF};
        vt[2]  = '{1'b0, 32'h44,  32'h0,        4'h0, 32'h040302FF, 1'b0, 1, 32'h040302FF};
        vt[3]  = '{1'b1, 32'h28,  32'h11223344, 4'hA, 32'h0,        1'b0, 1, 32'h040302FF};
        vt[4]  = '{1'b0, 32'h28,  32'h0,        4'h0, 32'h11003300, 1'b0, 1, 32'h040302FF};
        vt[5]  = '{1'b1, 32'h88,  32'h55555555, 4'hF, 32'h0,        1'b1, 1, 32'h040302FF};
        vt[6]  = '{1'b0, 32'h88,  32'h0,        4'h0, 32'h0,        1'b1, 1, 32'h040302FF};
        vt[7]  = '{1'b1, 32'h02,  32'h00000003, 4'hF, 32'h0,        1'b1, 1, 32'h040302FF};
        vt[8]  = '{1'b0, 32'h45,  32'h0,        4'h0, 32'h0,        1'b1, 1, 32'h040302FF};
        vt[9]  = '{1'b1, 32'h0C,  32'h12345678, 4'hF, 32'h0,        1'b1, 1, 32'h040302FF};
        vt[10] = '{1'b0, 32'h0C,  32'h0,        4'h0, 32'h0,        1'b0, 1, 32'h040302FF};
        vt[11] = '{1'b0, 32'h00,  32'h0,        4'h0, 32'h0,        1'b0, 1, 32'h040302FF};
        vt[12] = '{1'b0, 32'h04,  32'h0,        4'h0, 32'h0,        1'b0, 1, 32'h040302FF};
        vt[13] = '{1'b1, 32'h1C,  32'h99999999, 4'hF, 32'h0,        1'b1, 1, 32'h040302FF};

        repeat (2) @(negedge clk);
        chk("rst_pready",  256'(pready),  256'(0));
        chk("rst_pslverr", 256'(pslverr), 256'(0));
        chk("rst_prdata",  256'(prdata),  256'(0));
        chk("rst_start",   256'(start),   256'(0));
        chk("rst_busy",    256'(busy),    256'(0));
        chk("rst_control", 256'(control), 256'(0));
        chk("rst_opa",     256'(opa),     256'(0));
        chk("rst_opb",     256'(opb),     256'(0));
        chk("rst_sp_en",   256'(sp_en),   256'(0));
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apb($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].strb,
                vt[i].erd, vt[i].eerr, vt[i].elat);
            chk($sformatf("vec%0d_opa_line2", i), 256'(opa[95:64]), 256'(vt[i].eopa2));
        end
        chk("table_opa", 256'(opa), 256'({32'h0, 32'h040302FF, 32'h0, 32'h0}));
        chk("table_opb", 256'(opb), 256'({32'h0, 32'h0, 32'h11003300, 32'h0}));

        // Start pulse, busy, self-clearing bit0 and flag clear
        flags_in = 32'h77; flags_we = 1'b1;
        @(negedge clk);
        flags_we = 1'b0;
        apb("flags_load", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h77, 1'b0, 1);
        apb("ctrl_start", 1'b1, 32'h00, 32'h00002A03, 4'hF, 32'h0, 1'b0, 1);
        chk("start_after_commit", 256'(start),   256'(1));
        chk("busy_after_commit",  256'(busy),    256'(1));
        chk("control_o_written",  256'(control), 256'(32'h2A02));
        @(negedge clk);
        chk("start_one_cycle",    256'(start),   256'(0));
        chk("busy_released",      256'(busy),    256'(0));
        apb("ctrl_readback", 1'b0, 32'h00, 32'h0, 4'h0, 32'h2A02, 1'b0, 1);
        apb("flags_cleared", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h0, 1'b0, 1);

        // Byte-0 only start; core flag update lands on the start cycle
        apb("ctrl_start_b0", 1'b1, 32'h00, 32'hFFFFFF01, 4'h1, 32'h0, 1'b0, 1);
        chk("start_b0_pulse", 256'(start), 256'(1));
        flags_in = 32'h5; flags_we = 1'b1;
        @(negedge clk);
        flags_we = 1'b0;
        chk("control_b0", 256'(control), 256'(32'h2A00));
        apb("flags_we_wins", 1'b0, 32'h0C, 32'h0, 4'h0, 32'h5, 1'b0, 1);

        // Accesses rejected while the core is busy
        core_busy = 1'b1;
        p0 = sp_pulses;
        apb("sp0_wr_busy",  1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 1);
        apb("sp1_rd_busy",  1'b0, 32'h14, 32'h0,        4'h0, 32'h0, 1'b1, 1);
        apb("ctrl_wr_busy", 1'b1, 32'h00, 32'h00000005, 4'hF, 32'h0, 1'b1, 1);
        chk("busy_no_start",   256'(start),     256'(0));
        chk("busy_busy_o",     256'(busy),      256'(1));
        chk("busy_control",    256'(control),   256'(32'h2A00));
        chk("busy_opa",        256'(opa),       256'({32'h0, 32'h040302FF, 32'h0, 32'h0}));
        chk("busy_opb",        256'(opb),       256'({32'h0, 32'h0, 32'h11003300, 32'h0}));
        chk("busy_no_sp_req",  256'(sp_pulses), 256'(p0));
        core_busy = 1'b0;

        // Scratchpad read-through
        p0 = sp_pulses;
        apb("sp2_line5", 1'b0, 32'hB8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2);
        chk("sp2_pulses", 256'(sp_pulses), 256'(p0 + 1));
        chk("sp2_sel",    256'(last_sel),  256'(2));
        chk("sp2_idx",    256'(last_idx),  256'(5));
        apb("sp3_line15", 1'b0, 32'h1FC, 32'h0, 4'h0, sp_model(2'd3, 4'd15), 1'b0, 2);
        chk("sp3_sel",    256'(last_sel),  256'(3));
        chk("sp3_idx",    256'(last_idx),  256'(15));

        // Reset while waiting on the scratchpad
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'hB8;
        @(negedge clk);
        penable = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("midrst_pready",  256'(pready),  256'(0));
        chk("midrst_prdata",  256'(prdata),  256'(0));
        chk("midrst_pslverr", 256'(pslverr), 256'(0));
        chk("midrst_sp_en",   256'(sp_en),   256'(0));
        chk("midrst_opa",     256'(opa),     256'(0));
        chk("midrst_control", 256'(control), 256'(0));
        @(negedge clk);
        chk("midrst_pready_held", 256'(pready), 256'(0));
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        apb("post_rst_sp", 1'b0, 32'hB8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 2);
        apb("post_rst_wr", 1'b1, 32'h24, 32'h12345678, 4'hF, 32'h0, 1'b0, 1);
        chk("post_rst_opa1", 256'(opa[63:32]), 256'(32'h12345678));

        // penable without psel in IDLE is ignored
        @(negedge clk);
        penable = 1'b1; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hBAD0BAD0; pstrb = 4'hF;
        repeat (2) @(negedge clk);
        chk("stray_penable_pready", 256'(pready), 256'(0));
        penable = 1'b0;
        chk("stray_penable_opa0", 256'(opa[31:0]), 256'(0));

        // psel dropped during the response phase still completes the write
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h64; pwdata = 32'hA1B2C3D4; pstrb = 4'hF;
        @(negedge clk);
        psel = 1'b0;
        @(negedge clk);
        chk("psel_drop_opa3",   256'(opa[127:96]), 256'(32'hA1B2C3D4));
        chk("psel_drop_pready", 256'(pready),      256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary, required completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
